// File: rtl/flit_arbiter_if.sv
// Flit types plus the arbiter bundle: N upstream FIFO heads in, one registered flit out.
// The slave modport is the arbiter side; the master modport is the FIFO/downstream side.
package types;
  typedef struct packed {
    logic [3:0]  vc;
    logic [11:0] payload;
  } flit_t;
endpackage

interface flit_arbiter_if #(parameter int NUM_INPUTS = 4);
  localparam int IDX_W = $clog2(NUM_INPUTS);

  types::flit_t          in_flit [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_flit_valid;
  logic [NUM_INPUTS-1:0] in_flit_tail;
  logic [NUM_INPUTS-1:0] in_flit_ready;
  types::flit_t          out_flit;
  logic                  out_flit_valid;
  logic                  out_flit_ready;
  logic [IDX_W-1:0]      out_grant_index;

  modport slave (
    input  in_flit, in_flit_valid, in_flit_tail, out_flit_ready,
    output in_flit_ready, out_flit, out_flit_valid, out_grant_index
  );

  modport master (
    output in_flit, in_flit_valid, in_flit_tail, out_flit_ready,
    input  in_flit_ready, out_flit, out_flit_valid, out_grant_index
  );
endinterface

// File: rtl/flit_arbiter.sv
// Packet-locked round-robin flit arbiter: 1-cycle latency from input pop to out_flit_valid.
// A stalled output register (valid && !ready) blocks every input; a locked packet stalls other inputs.
module flit_arbiter #(
  parameter int NUM_INPUTS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  flit_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_index;
  logic [IDX_W-1:0] grant_index_q;
  logic             out_valid_q;
  types::flit_t     out_flit_q;

  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] next_rr;
  logic             sel_found;
  logic             can_load;
  logic             grant;

  // Descending scan so the smallest offset from rr_ptr is the last (winning) assignment.
  always_comb begin : sel_comb
    logic [IDX_W:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    if (state == LOCKED) begin
      sel_idx   = lock_index;
      sel_found = bus.in_flit_valid[lock_index];
    end else if (state == IDLE) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_INPUTS))
          cand = cand - (IDX_W+1)'(NUM_INPUTS);
        if (bus.in_flit_valid[cand[IDX_W-1:0]]) begin
          sel_found = 1'b1;
          sel_idx   = cand[IDX_W-1:0];
        end
      end
    end
  end

  assign can_load = !out_valid_q || bus.out_flit_ready;
  // rst_n gates the pop so FIFOs are not drained while reset is held.
  assign grant    = rst_n && can_load && sel_found;
  assign next_rr  = (sel_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_idx + IDX_W'(1);

  always_comb begin
    bus.in_flit_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      bus.in_flit_ready[i] = grant && (sel_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      lock_index    <= '0;
      out_valid_q   <= 1'b0;
      grant_index_q <= '0;
    end else begin
      if (can_load)
        out_valid_q <= grant;
      if (grant) begin
        grant_index_q <= sel_idx;
        if (bus.in_flit_tail[sel_idx]) begin
          state  <= IDLE;
          rr_ptr <= next_rr;
        end else begin
          state      <= LOCKED;
          lock_index <= sel_idx;
        end
      end else if (state != IDLE && state != LOCKED) begin
        state <= IDLE;
      end
    end
  end

  // Payload register is qualified by out_flit_valid and carries no reset.
  always_ff @(posedge clk) begin
    if (grant)
      out_flit_q <= bus.in_flit[sel_idx];
  end

  assign bus.out_flit        = out_flit_q;
  assign bus.out_flit_valid  = out_valid_q;
  assign bus.out_grant_index = grant_index_q;
endmodule

// File: tb/tb_flit_arbiter.sv
// Bench for flit_arbiter (NUM_INPUTS=4): per-input FIFO models feed the DUT, a scoreboard
// of expected (index, flit) pairs is checked on every output handshake.
module tb_flit_arbiter;
  import types::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flit_arbiter_if #(.NUM_INPUTS(4)) bus();
  flit_arbiter #(.NUM_INPUTS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic tail; flit_t f; } ent_t;
  typedef struct packed { logic [1:0] idx; flit_t f; } exp_t;

  ent_t inq [4][$];
  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  logic [3:0] last_rdy;
  logic       last_vld;
  logic [1:0] last_idx;
  flit_t      last_dat;

  function automatic flit_t mk(input int src, input int tag);
    flit_t f;
    f.vc      = src[3:0];
    f.payload = tag[11:0];
    return f;
  endfunction

  task automatic redrive();
    for (int i = 0; i < 4; i++) begin
      if (inq[i].size() > 0) begin
        bus.in_flit_valid[i] = 1'b1;
        bus.in_flit[i]       = inq[i][0].f;
        bus.in_flit_tail[i]  = inq[i][0].tail;
      end else begin
        bus.in_flit_valid[i] = 1'b0;
        bus.in_flit[i]       = '0;
        bus.in_flit_tail[i]  = 1'b0;
      end
    end
  endtask

  task automatic add(input int src, input int tag, input bit tail);
    ent_t e;
    e.tail = tail;
    e.f    = mk(src, tag);
    inq[src].push_back(e);
    redrive();
  endtask

  task automatic exp_push(input int src, input int tag);
    exp_t e;
    e.idx = src[1:0];
    e.f   = mk(src, tag);
    expq.push_back(e);
  endtask

  // One clock: sample at the falling edge, pop accepted flits just after the rising edge.
  task automatic cycle();
    logic [3:0] x;
    @(negedge clk);
    last_rdy = bus.in_flit_ready;
    last_vld = bus.out_flit_valid;
    last_idx = bus.out_grant_index;
    last_dat = bus.out_flit;
    x = bus.in_flit_valid & bus.in_flit_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (x[i]) void'(inq[i].pop_front());
    redrive();
  endtask

  task automatic run_until_empty(input int budget);
    for (int n = 0; n < budget && expq.size() != 0; n++) cycle();
    cycle();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_flit_valid === 1'b1 && bus.out_flit_ready === 1'b1) begin
      exp_t e;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_unexpected: got idx=%0d flit=%h, none expected",
                 bus.out_grant_index, bus.out_flit);
      end else begin
        e = expq.pop_front();
        if (bus.out_grant_index !== e.idx || bus.out_flit !== e.f) begin
          bad++;
          $display("FAIL scoreboard: got idx=%0d flit=%h want idx=%0d flit=%h",
                   bus.out_grant_index, bus.out_flit, e.idx, e.f);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_flit_ready = 1'b1;
    add(1, 'h010, 1);
    add(3, 'h030, 1);
    #12;
    total++;
    if (bus.out_flit_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_flit_valid);
    end
    total++;
    if (bus.in_flit_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_flit_ready);
    end
    total++;
    if (bus.out_grant_index !== 2'd0) begin
      bad++; $display("FAIL reset_grant_index: got %0d want 0", bus.out_grant_index);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_push(1, 'h010);
    exp_push(3, 'h030);
    cycle();
    total++;
    if (last_rdy !== 4'b0010 || last_vld !== 1'b0) begin
      bad++; $display("FAIL reset_first_grant: got rdy=%b vld=%b want rdy=0010 vld=0", last_rdy, last_vld);
    end
    cycle();
    total++;
    if (last_rdy !== 4'b1000 || last_vld !== 1'b1 || last_idx !== 2'd1) begin
      bad++; $display("FAIL reset_second_grant: got rdy=%b vld=%b idx=%0d want rdy=1000 vld=1 idx=1",
                      last_rdy, last_vld, last_idx);
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0 || bus.out_flit_valid !== 1'b0) begin
      bad++; $display("FAIL reset_drain: got pending=%0d vld=%b want pending=0 vld=0",
                      expq.size(), bus.out_flit_valid);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) begin
      add(0, 'h100 + k, 1);
      add(2, 'h200 + k, 1);
      exp_push(0, 'h100 + k);
      exp_push(2, 'h200 + k);
    end
    cycle();
    total++;
    if (last_rdy !== 4'b0001) begin
      bad++; $display("FAIL rr_first: got rdy=%b want 0001", last_rdy);
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      total++;
      if (last_vld !== 1'b1) begin
        bad++; $display("FAIL rr_throughput beat %0d: got vld=%b want 1", k, last_vld);
      end
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0) begin
      bad++; $display("FAIL rr_drain: got pending=%0d want 0", expq.size());
    end
  endtask

  task automatic test_wrap();
    add(0, 'h060, 1);
    add(3, 'h360, 1);
    exp_push(3, 'h360);
    exp_push(0, 'h060);
    cycle();
    total++;
    if (last_rdy !== 4'b1000) begin
      bad++; $display("FAIL wrap_first: got rdy=%b want 1000", last_rdy);
    end
    cycle();
    total++;
    if (last_rdy !== 4'b0001) begin
      bad++; $display("FAIL wrap_second: got rdy=%b want 0001", last_rdy);
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0) begin
      bad++; $display("FAIL wrap_drain: got pending=%0d want 0", expq.size());
    end
  endtask

  task automatic test_lock();
    logic [3:0] want [6];
    want = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
    add(1, 'h110, 0);
    add(1, 'h111, 0);
    add(3, 'h330, 1);
    exp_push(1, 'h110);
    exp_push(1, 'h111);
    exp_push(1, 'h112);
    exp_push(3, 'h330);
    for (int c = 0; c < 6; c++) begin
      if (c == 4) add(1, 'h112, 1);
      cycle();
      total++;
      if (last_rdy !== want[c]) begin
        bad++; $display("FAIL lock_ready cycle %0d: got rdy=%b want %b", c, last_rdy, want[c]);
      end
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0) begin
      bad++; $display("FAIL lock_drain: got pending=%0d want 0", expq.size());
    end
  endtask

  task automatic test_backpressure();
    bus.out_flit_ready = 1'b0;
    add(2, 'h240, 1);
    add(2, 'h241, 1);
    exp_push(2, 'h240);
    exp_push(2, 'h241);
    cycle();
    total++;
    if (last_rdy !== 4'b0100) begin
      bad++; $display("FAIL bp_load: got rdy=%b want 0100", last_rdy);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (last_vld !== 1'b1 || last_idx !== 2'd2 || last_dat !== mk(2, 'h240) || last_rdy !== 4'b0000) begin
        bad++; $display("FAIL bp_hold cycle %0d: got vld=%b idx=%0d flit=%h rdy=%b want vld=1 idx=2 flit=%h rdy=0000",
                        c, last_vld, last_idx, last_dat, last_rdy, mk(2, 'h240));
      end
    end
    bus.out_flit_ready = 1'b1;
    cycle();
    total++;
    if (last_rdy !== 4'b0100) begin
      bad++; $display("FAIL bp_release: got rdy=%b want 0100", last_rdy);
    end
    cycle();
    total++;
    if (last_vld !== 1'b1 || last_dat !== mk(2, 'h241)) begin
      bad++; $display("FAIL bp_next: got vld=%b flit=%h want vld=1 flit=%h", last_vld, last_dat, mk(2, 'h241));
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0) begin
      bad++; $display("FAIL bp_drain: got pending=%0d want 0", expq.size());
    end
  endtask

  task automatic test_midpacket_reset();
    bus.out_flit_ready = 1'b0;
    add(2, 'h250, 0);
    cycle();
    total++;
    if (last_rdy !== 4'b0100) begin
      bad++; $display("FAIL mid_head: got rdy=%b want 0100", last_rdy);
    end
    add(0, 'h050, 1);
    add(2, 'h251, 1);
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.out_flit_valid !== 1'b0 || bus.in_flit_ready !== 4'b0000 || bus.out_grant_index !== 2'd0) begin
      bad++; $display("FAIL mid_async_reset: got vld=%b rdy=%b idx=%0d want vld=0 rdy=0000 idx=0",
                      bus.out_flit_valid, bus.in_flit_ready, bus.out_grant_index);
    end
    bus.out_flit_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_push(0, 'h050);
    exp_push(2, 'h251);
    cycle();
    total++;
    if (last_rdy !== 4'b0001) begin
      bad++; $display("FAIL mid_first_grant: got rdy=%b want 0001", last_rdy);
    end
    cycle();
    total++;
    if (last_rdy !== 4'b0100) begin
      bad++; $display("FAIL mid_second_grant: got rdy=%b want 0100", last_rdy);
    end
    run_until_empty(20);
    total++;
    if (expq.size() != 0) begin
      bad++; $display("FAIL mid_drain: got pending=%0d want 0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_lock();
    test_backpressure();
    test_midpacket_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
